// File: rtl/memory_control.sv
// Arbitrates icache and dcache requests onto a single RAM port.
// Round-robin grant, per-transaction timeout, sticky error flag.
module memory_control #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DSERV = 2'd1;
  localparam logic [1:0] ISERV = 2'd2;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam logic LG_D = 1'b0;
  localparam logic LG_I = 1'b1;

  localparam int CLG = $clog2(TIMEOUT + 1);
  localparam int CW  = (CLG > 8) ? CLG : 8;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic          lastgrant;
  logic          lastgrant_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cnt_inc;
  logic          memerr_n;

  logic dreq;
  logic ireq;
  logic acc;
  logic err;
  logic tmo;
  logic sreq;

  assign dreq    = dREN | dWEN;
  assign ireq    = iREN;
  assign acc     = (ramstate == RS_ACCESS);
  assign err     = (ramstate == RS_ERROR);
  assign cnt_inc = cnt + CW'(1);
  // this cycle is the TIMEOUT-th one spent waiting
  assign tmo     = (cnt_inc == TMAX);
  assign sreq    = (state == ISERV) ? ireq : dreq;

  assign iload = ramload;
  assign dload = ramload;

  // arbitration, completion, drop, error and timeout decisions
  always_comb begin
    state_n     = state;
    lastgrant_n = lastgrant;
    cnt_n       = '0;
    memerr_n    = memerr;
    unique case (state)
      IDLE: begin
        if (dreq && ireq) begin
          state_n = (lastgrant == LG_I) ? DSERV : ISERV;
        end else if (dreq) begin
          state_n = DSERV;
        end else if (ireq) begin
          state_n = ISERV;
        end
      end
      DSERV, ISERV: begin
        if (!sreq) begin
          state_n = IDLE;
        end else if (acc) begin
          state_n     = IDLE;
          lastgrant_n = (state == ISERV) ? LG_I : LG_D;
        end else if (err || tmo) begin
          state_n  = IDLE;
          memerr_n = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM strobes, address mux and cache stall signals
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~(dreq & acc);
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~(ireq & acc);
      end
      default: ;
    endcase
  end

  // state, round-robin memory, timeout counter and sticky error
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      lastgrant <= LG_I;
      cnt       <= '0;
      memerr    <= 1'b0;
    end else begin
      state     <= state_n;
      lastgrant <= lastgrant_n;
      cnt       <= cnt_n;
      memerr    <= memerr_n;
    end
  end

endmodule

// File: tb/tb_memory_control.sv
// Bench for memory_control: directed vector table, hand sequences
// for timeout/error/reset, and random traffic against a model.
module tb_memory_control;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  int n_tests = 0;
  int n_fail  = 0;

  memory_control #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h40; daddr = 32'h80;
    dstore = 32'hDEADBEEF;
    ramload = 32'h8C010004;
    ramstate = 2'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    chk("rst_ren", 32'(ramREN), 0);
    chk("rst_wen", 32'(ramWEN), 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    chk("rst_err", 32'(memerr), 0);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        i, d, w;
    logic [1:0]  rs;
    logic        iw, dw, ren, wen;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic i, logic d, logic w,
                              logic [1:0] rs, logic iw,
                              logic dw, logic ren, logic wen,
                              logic [31:0] addr);
    vec_t v;
    v.i = i; v.d = d; v.w = w; v.rs = rs;
    v.iw = iw; v.dw = dw; v.ren = ren; v.wen = wen;
    v.addr = addr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // owner: 0 nobody, 1 dcache, 2 icache
  int m_owner;
  bit m_last_i;
  int m_waited;
  bit m_err;

  task automatic model_reset();
    m_owner = 0; m_last_i = 1; m_waited = 0; m_err = 0;
  endtask

  task automatic model_check();
    bit dq;
    bit hit;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    bit e_iw, e_dw, e_ren, e_wen;
    dq = dREN | dWEN;
    hit = (ramstate == 2'd2);
    e_addr = 0; e_store = 0;
    e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0;
    if (m_owner == 1) begin
      e_addr = daddr; e_store = dstore;
      e_wen = dWEN; e_ren = dREN && !dWEN;
      e_dw = !(dq && hit);
    end else if (m_owner == 2) begin
      e_addr = iaddr; e_ren = 1;
      e_iw = !(iREN && hit);
    end
    chk("m_iwait", 32'(iwait), 32'(e_iw));
    chk("m_dwait", 32'(dwait), 32'(e_dw));
    chk("m_ren", 32'(ramREN), 32'(e_ren));
    chk("m_wen", 32'(ramWEN), 32'(e_wen));
    chk("m_addr", ramaddr, e_addr);
    chk("m_store", ramstore, e_store);
    chk("m_err", 32'(memerr), 32'(m_err));
    if (!iwait) chk("m_iload", iload, ramload);
    if (!dwait) chk("m_dload", dload, ramload);
    chk("m_excl", 32'(iwait | dwait), 1);
  endtask

  task automatic model_step();
    bit dq;
    bit want;
    dq = dREN | dWEN;
    if (m_owner == 0) begin
      m_waited = 0;
      if (dq && iREN) m_owner = m_last_i ? 1 : 2;
      else if (dq) m_owner = 1;
      else if (iREN) m_owner = 2;
    end else begin
      want = (m_owner == 1) ? dq : iREN;
      if (!want) begin
        m_owner = 0;
      end else if (ramstate == 2'd2) begin
        m_last_i = (m_owner == 2);
        m_owner = 0;
      end else if (ramstate == 2'd3) begin
        m_err = 1; m_owner = 0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_err = 1; m_owner = 0;
        end
      end
    end
  endtask

  initial begin
    int serve;
    bit sawlow;
    bit ri, rd, rw;

    // A=ACCESS B=BUSY F=FREE
    tbl.push_back(mk(1,1,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(1,1,0,2, 1,0,1,0, 32'h80));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(1,1,0,2, 0,1,1,0, 32'h40));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(1,1,0,2, 1,0,1,0, 32'h80));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(1,1,0,2, 0,1,1,0, 32'h40));
    tbl.push_back(mk(0,1,1,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,1,1,1, 1,1,0,1, 32'h80));
    tbl.push_back(mk(0,1,1,2, 1,0,0,1, 32'h80));
    tbl.push_back(mk(0,0,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(1,0,0,1, 1,1,1,0, 32'h40));
    tbl.push_back(mk(1,0,0,1, 1,1,1,0, 32'h40));
    tbl.push_back(mk(1,0,0,2, 0,1,1,0, 32'h40));
    tbl.push_back(mk(0,0,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,0,0,2, 1,1,0,0, 32'h80));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,1,0,2, 1,0,1,0, 32'h80));
    tbl.push_back(mk(0,0,0,0, 1,1,0,0, 0));

    do_reset();
    foreach (tbl[k]) begin
      iREN = tbl[k].i; dREN = tbl[k].d; dWEN = tbl[k].w;
      ramstate = tbl[k].rs;
      @(negedge CLK);
      chk($sformatf("v%0d_iwait", k), 32'(iwait), 32'(tbl[k].iw));
      chk($sformatf("v%0d_dwait", k), 32'(dwait), 32'(tbl[k].dw));
      chk($sformatf("v%0d_ren", k), 32'(ramREN), 32'(tbl[k].ren));
      chk($sformatf("v%0d_wen", k), 32'(ramWEN), 32'(tbl[k].wen));
      chk($sformatf("v%0d_addr", k), ramaddr, tbl[k].addr);
      chk($sformatf("v%0d_store", k), ramstore,
          (tbl[k].addr == 32'h80) ? 32'hDEADBEEF : 32'h0);
      if (!tbl[k].iw) chk($sformatf("v%0d_iload", k), iload, 32'h8C010004);
      if (!tbl[k].dw) chk($sformatf("v%0d_dload", k), dload, 32'h8C010004);
      chk($sformatf("v%0d_err", k), 32'(memerr), 0);
      @(posedge CLK);
      #1;
    end

    // timeout: ramstate held BUSY
    do_reset();
    dREN = 1; ramstate = 2'd1;
    serve = 0; sawlow = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!dwait) sawlow = 1;
      if (ramREN) serve++;
      else if (serve > 0) break;
      @(posedge CLK);
      #1;
    end
    chk("tmo_cycles", 32'(serve), 32'(TMO));
    chk("tmo_nodwait", 32'(sawlow), 0);
    chk("tmo_err", 32'(memerr), 1);
    @(posedge CLK);
    #1;
    ramstate = 2'd2;
    @(negedge CLK);
    chk("tmo_succ_dwait", 32'(dwait), 0);
    chk("tmo_succ_err", 32'(memerr), 1);
    @(posedge CLK);
    #1;
    dREN = 0; ramstate = 2'd0;
    @(negedge CLK);
    chk("tmo_err_sticky", 32'(memerr), 1);

    // ERROR during ISERV, then re-grant
    do_reset();
    iREN = 1;
    @(posedge CLK);
    #1;
    ramstate = 2'd3;
    @(negedge CLK);
    chk("er_iwait", 32'(iwait), 1);
    chk("er_ren", 32'(ramREN), 1);
    @(posedge CLK);
    #1;
    ramstate = 2'd0;
    @(negedge CLK);
    chk("er_idle_ren", 32'(ramREN), 0);
    chk("er_err", 32'(memerr), 1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("er_regrant", 32'(ramREN), 1);
    chk("er_regrant_addr", ramaddr, 32'h40);

    // reset pulse in the middle of DSERV
    @(posedge CLK);
    #1;
    iREN = 0; dREN = 1; ramstate = 2'd1;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rp_dserv_addr", ramaddr, 32'h80);
    #2;
    nRST = 0;
    #1;
    chk("rp_dwait", 32'(dwait), 1);
    chk("rp_iwait", 32'(iwait), 1);
    chk("rp_ren", 32'(ramREN), 0);
    chk("rp_addr", ramaddr, 0);
    chk("rp_store", ramstore, 0);
    chk("rp_err", 32'(memerr), 0);

    // random traffic against the model
    do_reset();
    model_reset();
    ri = 0; rd = 0; rw = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        ri = 1'($urandom); rd = 1'($urandom); rw = 1'($urandom);
      end
      iREN = ri; dREN = rd; dWEN = rw;
      iaddr = $urandom; daddr = $urandom;
      dstore = $urandom; ramload = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      @(negedge CLK);
      model_check();
      @(posedge CLK);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
